// File: rtl/alu_seq16.sv
// alu_seq16: runs 16-bit operations on an external 8-bit ALU as two chained
// byte passes, using the ALU's own carry flag to link the passes.
// Optional feature macro: ALU_SEQ16_SHIFT_EN enables op A (SHL) and op B (SHR).
//
// ALU operation encoding driven on alu_op (5 bits):
//   00 ADD  01 ADC  02 SUB  03 SBC  04 AND  05 OR   06 XOR  07 NOT(B)
//   08 INC(B) 09 DEC(B) 0A SHL(A) 0B RCL(A) 0C SHR(A) 0D RCR(A)  1F NOP
// The ALU registers result/flags one clock after its inputs; NOP leaves CF alone.
module alu_seq16 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] result,
    output logic        cf,
    output logic        zf,
    output logic        sf,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [4:0]  alu_op,
    input  logic [7:0]  alu_result,
    input  logic        alu_cf,
    input  logic        alu_zf,
    input  logic        alu_sf
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_P1   = 2'd1;
    localparam logic [1:0] ST_P2   = 2'd2;
    localparam logic [1:0] ST_CAP  = 2'd3;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_INC = 4'h6;
    localparam logic [3:0] OP_DEC = 4'h7;
    localparam logic [3:0] OP_CMP = 4'h8;
    localparam logic [3:0] OP_SHL = 4'hA;
    localparam logic [3:0] OP_SHR = 4'hB;

    localparam logic [4:0] A_ADD = 5'h00;
    localparam logic [4:0] A_ADC = 5'h01;
    localparam logic [4:0] A_SUB = 5'h02;
    localparam logic [4:0] A_SBC = 5'h03;
    localparam logic [4:0] A_AND = 5'h04;
    localparam logic [4:0] A_OR  = 5'h05;
    localparam logic [4:0] A_XOR = 5'h06;
    localparam logic [4:0] A_NOT = 5'h07;
    localparam logic [4:0] A_INC = 5'h08;
    localparam logic [4:0] A_DEC = 5'h09;
    localparam logic [4:0] A_SHL = 5'h0A;
    localparam logic [4:0] A_RCL = 5'h0B;
    localparam logic [4:0] A_SHR = 5'h0C;
    localparam logic [4:0] A_RCR = 5'h0D;
    localparam logic [4:0] A_NOP = 5'h1F;

    logic [1:0]  state_reg;
    logic [3:0]  op_reg;
    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic [7:0]  byte1_reg;
    logic        z1_reg;
    logic        s1_reg;
    logic [15:0] result_reg;
    logic        cf_reg;
    logic        zf_reg;
    logic        sf_reg;
    logic        done_reg;
    logic        err_reg;
    logic        first_pass;

    // Op codes this build can execute; everything else is rejected with err.
    function automatic logic op_legal(input logic [3:0] o);
        logic ok;
        case (o)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_NOT, OP_INC, OP_DEC, OP_CMP: ok = 1'b1;
`ifdef ALU_SEQ16_SHIFT_EN
            OP_SHL, OP_SHR:                 ok = 1'b1;
`endif
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign first_pass = (state_reg == ST_P1);
    assign busy       = (state_reg != ST_IDLE);
    assign done       = done_reg;
    assign err        = err_reg;
    assign result     = result_reg;
    assign cf         = cf_reg;
    assign zf         = zf_reg;
    assign sf         = sf_reg;

    // ALU operand/operation select for the current pass; NOP whenever no pass runs.
    always_comb begin
        alu_a  = 8'h00;
        alu_b  = 8'h00;
        alu_op = A_NOP;
        if (state_reg == ST_P1 || state_reg == ST_P2) begin
            case (op_reg)
                OP_ADD: begin
                    alu_a  = first_pass ? a_reg[7:0] : a_reg[15:8];
                    alu_b  = first_pass ? b_reg[7:0] : b_reg[15:8];
                    alu_op = first_pass ? A_ADD : A_ADC;
                end
                OP_SUB, OP_CMP: begin
                    alu_a  = first_pass ? a_reg[7:0] : a_reg[15:8];
                    alu_b  = first_pass ? b_reg[7:0] : b_reg[15:8];
                    alu_op = first_pass ? A_SUB : A_SBC;
                end
                OP_AND, OP_OR, OP_XOR: begin
                    alu_a  = first_pass ? a_reg[7:0] : a_reg[15:8];
                    alu_b  = first_pass ? b_reg[7:0] : b_reg[15:8];
                    alu_op = (op_reg == OP_AND) ? A_AND :
                             (op_reg == OP_OR)  ? A_OR  : A_XOR;
                end
                OP_NOT: begin
                    alu_b  = first_pass ? b_reg[7:0] : b_reg[15:8];
                    alu_op = A_NOT;
                end
                OP_INC: begin
                    // high byte absorbs the increment carry as 0 + b_hi + CF
                    alu_b  = first_pass ? b_reg[7:0] : b_reg[15:8];
                    alu_op = first_pass ? A_INC : A_ADC;
                end
                OP_DEC: begin
                    // high byte absorbs the decrement borrow as b_hi - 0 - CF
                    alu_a  = first_pass ? 8'h00 : b_reg[15:8];
                    alu_b  = first_pass ? b_reg[7:0] : 8'h00;
                    alu_op = first_pass ? A_DEC : A_SBC;
                end
`ifdef ALU_SEQ16_SHIFT_EN
                OP_SHL: begin
                    alu_a  = first_pass ? a_reg[7:0] : a_reg[15:8];
                    alu_op = first_pass ? A_SHL : A_RCL;
                end
                OP_SHR: begin
                    // right shift walks from the high byte down
                    alu_a  = first_pass ? a_reg[15:8] : a_reg[7:0];
                    alu_op = first_pass ? A_SHR : A_RCR;
                end
`endif
                default: begin
                    alu_op = A_NOP;
                end
            endcase
        end
    end

    // Sequencer: accept, two passes, capture; latched results held until the next done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ST_IDLE;
            op_reg     <= 4'h0;
            a_reg      <= 16'h0000;
            b_reg      <= 16'h0000;
            byte1_reg  <= 8'h00;
            z1_reg     <= 1'b0;
            s1_reg     <= 1'b0;
            result_reg <= 16'h0000;
            cf_reg     <= 1'b0;
            zf_reg     <= 1'b0;
            sf_reg     <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (op_legal(op)) begin
                            op_reg    <= op;
                            a_reg     <= a;
                            b_reg     <= b;
                            state_reg <= ST_P1;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                ST_P1: begin
                    state_reg <= ST_P2;
                end
                ST_P2: begin
                    byte1_reg <= alu_result;
                    z1_reg    <= alu_zf;
                    s1_reg    <= alu_sf;
                    state_reg <= ST_CAP;
                end
                default: begin
                    if (op_reg == OP_CMP)
                        result_reg <= a_reg;
                    else if (op_reg == OP_SHR)
                        result_reg <= {byte1_reg, alu_result};
                    else
                        result_reg <= {alu_result, byte1_reg};
                    cf_reg    <= alu_cf;
                    zf_reg    <= z1_reg & alu_zf;
                    sf_reg    <= (op_reg == OP_SHR) ? s1_reg : alu_sf;
                    done_reg  <= 1'b1;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq16.sv
// Directed testbench for alu_seq16 with a behavioural 8-bit ALU attached.
module tb_alu_seq16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'h0;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        busy, done, err, cf, zf, sf;
    logic [15:0] result;
    logic [7:0]  alu_a, alu_b;
    logic [4:0]  alu_op;
    logic [7:0]  alu_result;
    logic        alu_cf, alu_zf, alu_sf;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_seq16 dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .err(err), .result(result),
        .cf(cf), .zf(zf), .sf(sf),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_cf(alu_cf), .alu_zf(alu_zf), .alu_sf(alu_sf)
    );

    // Behavioural 8-bit ALU: registered result/flags, NOP holds everything.
    always @(posedge clk or negedge reset_n) begin
        logic [8:0] t;
        logic       upd;
        if (!reset_n) begin
            alu_result <= 8'h00; alu_cf <= 1'b0; alu_zf <= 1'b0; alu_sf <= 1'b0;
        end else begin
            upd = 1'b1;
            t = {alu_cf, alu_result};
            case (alu_op)
                5'h00: t = {1'b0, alu_a} + {1'b0, alu_b};
                5'h01: t = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cf};
                5'h02: t = {1'b0, alu_a} - {1'b0, alu_b};
                5'h03: t = {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, alu_cf};
                5'h04: t = {1'b0, alu_a & alu_b};
                5'h05: t = {1'b0, alu_a | alu_b};
                5'h06: t = {1'b0, alu_a ^ alu_b};
                5'h07: t = {1'b0, ~alu_b};
                5'h08: t = {1'b0, alu_b} + 9'd1;
                5'h09: t = {1'b0, alu_b} - 9'd1;
                5'h0A: t = {alu_a, 1'b0};
                5'h0B: t = {alu_a, alu_cf};
                5'h0C: t = {alu_a[0], 1'b0, alu_a[7:1]};
                5'h0D: t = {alu_a[0], alu_cf, alu_a[7:1]};
                default: upd = 1'b0;
            endcase
            if (upd) begin
                alu_result <= t[7:0];
                alu_cf     <= t[8];
                alu_zf     <= (t[7:0] == 8'h00);
                alu_sf     <= t[7];
            end
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op (start for one clock) and check latency, result and flags.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [15:0] av,
                          input logic [15:0] bv, input logic [15:0] er,
                          input logic ec, input logic ez, input logic es);
        int n;
        op = o; a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " busy"}, {15'd0, busy}, 16'd1);
        n = 0;
        while (!done && n < 10) begin
            tick();
            n++;
        end
        check({tag, " latency"}, n[15:0], 16'd3);
        check({tag, " result"}, result, er);
        check({tag, " cf"}, {15'd0, cf}, {15'd0, ec});
        check({tag, " zf"}, {15'd0, zf}, {15'd0, ez});
        check({tag, " sf"}, {15'd0, sf}, {15'd0, es});
        check({tag, " busy at done"}, {15'd0, busy}, 16'd0);
        $display("op %h a=%h b=%h -> result=%h cf=%b zf=%b sf=%b", o, av, bv, result, cf, zf, sf);
    endtask

    // Present an unsupported op while idle: err pulses once, nothing else moves.
    task automatic try_illegal(input string tag, input logic [3:0] o);
        logic [15:0] held;
        held = result;
        op = o; a = 16'hAAAA; b = 16'h5555; start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " err"}, {15'd0, err}, 16'd1);
        check({tag, " busy"}, {15'd0, busy}, 16'd0);
        check({tag, " result held"}, result, held);
        tick();
        check({tag, " err one cycle"}, {15'd0, err}, 16'd0);
        check({tag, " alu_op idle"}, {11'd0, alu_op}, 16'h001F);
        $display("illegal op %h -> err pulse, busy=%b", o, busy);
    endtask

    initial begin
        int dones;
        int errs;

        // reset held, then released
        tick(); tick();
        check("rst busy", {15'd0, busy}, 16'd0);
        check("rst done", {15'd0, done}, 16'd0);
        check("rst err", {15'd0, err}, 16'd0);
        check("rst result", result, 16'h0000);
        check("rst flags", {13'd0, cf, zf, sf}, 16'd0);
        check("rst alu_a/b", {alu_a, alu_b}, 16'h0000);
        check("rst alu_op", {11'd0, alu_op}, 16'h001F);
        reset_n = 1'b1;
        tick();
        check("idle alu_op", {11'd0, alu_op}, 16'h001F);
        $display("reset released: busy=%b alu_op=%h", busy, alu_op);

        run_op("ADD", 4'h0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0);
        run_op("SUB", 4'h1, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        // accepted in the done cycle of SUB
        run_op("CMP", 4'h8, 16'h1234, 16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0);
        run_op("INC", 4'h6, 16'h1234, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 1'b0);
        run_op("DEC", 4'h7, 16'h0000, 16'h0100, 16'h00FF, 1'b0, 1'b0, 1'b0);
        run_op("AND", 4'h2, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b1);
        run_op("XOR", 4'h4, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0);
        run_op("NOT", 4'h5, 16'h0000, 16'h00FF, 16'hFF00, 1'b0, 1'b0, 1'b1);
        run_op("OR",  4'h3, 16'h0F00, 16'h00F1, 16'h0FF1, 1'b0, 1'b0, 1'b0);
        tick();
        check("done one cycle", {15'd0, done}, 16'd0);

        try_illegal("op C", 4'hC);
        try_illegal("op 9", 4'h9);

`ifdef ALU_SEQ16_SHIFT_EN
        run_op("SHL", 4'hA, 16'h80C0, 16'h0000, 16'h0180, 1'b1, 1'b0, 1'b0);
        run_op("SHR", 4'hB, 16'h0101, 16'h0000, 16'h0080, 1'b1, 1'b0, 1'b0);
        tick();
`else
        try_illegal("SHL off", 4'hA);
        try_illegal("SHR off", 4'hB);
`endif

        // start pulsed while busy is ignored: one done, no err
        op = 4'h0; a = 16'h0102; b = 16'h0304; start = 1'b1;
        tick();
        op = 4'hC; start = 1'b1;
        tick();
        start = 1'b0;
        dones = 0; errs = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) dones++;
            if (err) errs++;
            tick();
        end
        check("busy start dones", dones[15:0], 16'd1);
        check("busy start errs", errs[15:0], 16'd0);
        check("busy start result", result, 16'h0406);
        $display("start while busy: dones=%0d errs=%0d result=%h", dones, errs, result);

        // reset during P2 aborts without done
        op = 4'h0; a = 16'h1111; b = 16'h2222; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        check("abort busy", {15'd0, busy}, 16'd0);
        check("abort done", {15'd0, done}, 16'd0);
        check("abort alu_op", {11'd0, alu_op}, 16'h001F);
        check("abort result", result, 16'h0000);
        #5;
        reset_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) dones++;
        end
        check("abort no done", dones[15:0], 16'd0);
        $display("reset in P2: busy=%b dones=%0d", busy, dones);

        // sequencer still works after the abort
        run_op("ADD2", 4'h0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
